// File: rtl/dsp_boot_loader.sv
// rtl/dsp_boot_loader.sv - byte-stream loader for dsp instruction/data memories
// Holds the core in reset until a 'G' command; 'I'/'D' frames fill memory from address 0.
module dsp_boot_loader #(
  parameter int WORD_W  = 16,
  parameter int IADDR_W = 10,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0]  imem_wdata,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [WORD_W-1:0]  dmem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);

  localparam int AW = (IADDR_W > DADDR_W) ? IADDR_W : DADDR_W;
  localparam int CW = AW + 1;
  localparam logic [16:0] I_LIMIT = 17'(2**IADDR_W);
  localparam logic [16:0] D_LIMIT = 17'(2**DADDR_W);

  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_G = 8'h47;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_RUN,
    S_ERR
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic         r_sel_d;
  logic [7:0]   r_cnt_hi;
  logic [7:0]   r_hi;
  logic [CW-1:0] r_n;
  logic [AW-1:0] r_idx;

  logic         r_pend;
  logic         r_pend_d;
  logic [AW-1:0] r_pend_idx;
  logic [15:0]  r_pend_word;

  logic         w_accept;
  logic         w_wr;
  logic         w_last;
  logic [15:0]  w_count;
  logic [16:0]  w_limit;

  assign in_ready = (r_state != S_RUN) && (r_state != S_ERR);
  assign w_accept = in_valid & in_ready;
  assign w_count  = {r_cnt_hi, in_data};
  assign w_limit  = r_sel_d ? D_LIMIT : I_LIMIT;
  assign w_last   = (({1'b0, r_idx} + CW'(1)) == r_n);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wr         = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (in_data == CMD_I || in_data == CMD_D) begin
            w_state_next = S_CNT_HI;
          end else if (in_data == CMD_G) begin
            w_state_next = S_RUN;
          end else begin
            w_state_next = S_ERR;
          end
        end
        S_CNT_HI: w_state_next = S_CNT_LO;
        S_CNT_LO: begin
          if (w_count == 16'd0 || {1'b0, w_count} > w_limit) begin
            w_state_next = S_ERR;
          end else begin
            w_state_next = S_DAT_HI;
          end
        end
        S_DAT_HI: w_state_next = S_DAT_LO;
        S_DAT_LO: begin
          w_wr         = 1'b1;
          w_state_next = w_last ? S_IDLE : S_DAT_HI;
        end
        default: ;
      endcase
    end
  end

  // Frame bookkeeping; the word is staged one cycle before the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_d     <= 1'b0;
      r_cnt_hi    <= 8'd0;
      r_hi        <= 8'd0;
      r_n         <= '0;
      r_idx       <= '0;
      r_pend      <= 1'b0;
      r_pend_d    <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_word <= 16'd0;
    end else begin
      r_pend <= w_wr;
      if (w_wr) begin
        r_pend_d    <= r_sel_d;
        r_pend_idx  <= r_idx;
        r_pend_word <= {r_hi, in_data};
      end
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            r_sel_d <= (in_data == CMD_D);
            r_idx   <= '0;
          end
          S_CNT_HI: r_cnt_hi <= in_data;
          S_CNT_LO: r_n      <= CW'(w_count);
          S_DAT_HI: r_hi     <= in_data;
          S_DAT_LO: r_idx    <= r_idx + AW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= r_pend & ~r_pend_d;
      dmem_we <= r_pend & r_pend_d;
      if (r_pend && !r_pend_d) begin
        imem_addr  <= r_pend_idx[IADDR_W-1:0];
        imem_wdata <= WORD_W'(r_pend_word);
      end
      if (r_pend && r_pend_d) begin
        dmem_addr  <= r_pend_idx[DADDR_W-1:0];
        dmem_wdata <= WORD_W'(r_pend_word);
      end
      cpu_reset <= (r_state != S_RUN);
      done      <= (r_state == S_RUN);
      error     <= (r_state == S_ERR);
    end
  end

endmodule
